alien_grid_renderer: RTL and testbench

- Downstream of the alien-fall display counter. Consumes its draw-enable, row offset (0..40) and game-over signals.
- Repaints the alien formation on the 160x120, 3-bit-colour VGA adapter, one pixel per clock, using the adapter's x/y/colour/plot inputs.
- Each pass erases the formation at the previously drawn offset, then draws it at the new offset.
- Skips aliens whose alive bit is clear, and reports completion with a one-cycle pulse.

---
 rtl/alien_grid_renderer.sv | 199 +++++++++++++++++++
 tb/tb_alien_grid_renderer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/alien_grid_renderer.sv
// Repaints the alien formation on a 160x120 VGA adapter, one pixel per clock.
// Each pass erases the formation at the previous offset, then draws it at the new one.
module alien_grid_renderer #(
    parameter int unsigned ALIEN_COLS   = 8,
    parameter int unsigned ALIEN_ROWS   = 3,
    parameter int unsigned ALIEN_W      = 8,
    parameter int unsigned ALIEN_H      = 4,
    parameter int unsigned X_SPACING    = 12,
    parameter int unsigned Y_SPACING    = 8,
    parameter int unsigned X_ORIGIN     = 16,
    parameter int unsigned Y_ORIGIN     = 8,
    parameter logic [2:0]  ALIEN_COLOUR = 3'b010,
    parameter logic [2:0]  BG_COLOUR    = 3'b000
) (
    input  logic                             Clock,
    input  logic                             Reset,
    input  logic                             drawEn,
    input  logic [5:0]                       rowOffset,
    input  logic                             gameOver,
    input  logic [ALIEN_ROWS*ALIEN_COLS-1:0] aliveMask,
    output logic [7:0]                       x,
    output logic [6:0]                       y,
    output logic [2:0]                       colour,
    output logic                             plot,
    output logic                             busy,
    output logic                             done
);
    localparam int unsigned MASK_W = ALIEN_ROWS * ALIEN_COLS;
    localparam int unsigned IDX_W  = $clog2(MASK_W + 1);
    localparam int unsigned PX_W   = (ALIEN_W > 1)    ? $clog2(ALIEN_W)    : 1;
    localparam int unsigned PY_W   = (ALIEN_H > 1)    ? $clog2(ALIEN_H)    : 1;
    localparam int unsigned COL_W  = (ALIEN_COLS > 1) ? $clog2(ALIEN_COLS) : 1;
    localparam int unsigned ROW_W  = (ALIEN_ROWS > 1) ? $clog2(ALIEN_ROWS) : 1;
    localparam int unsigned CW     = 9;
    localparam int unsigned SCR_W  = 160;
    localparam int unsigned SCR_H  = 120;

    typedef enum logic [2:0] {S_IDLE, S_LATCH, S_ERASE, S_DRAW, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [PX_W-1:0]     px_q, px_d;
    logic [PY_W-1:0]     py_q, py_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [5:0]          new_offset_q, new_offset_d;
    logic [5:0]          drawn_offset_q, drawn_offset_d;
    logic                has_drawn_q, has_drawn_d;
    logic [MASK_W-1:0]   mask_q, mask_d;
    logic [7:0]          x_q, x_d;
    logic [6:0]          y_q, y_d;
    logic [2:0]          colour_q, colour_d;
    logic                plot_q, plot_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [5:0]          cur_offset;
    logic [CW-1:0]       x_pix, y_pix;
    logic [IDX_W-1:0]    mask_idx;
    logic                on_screen, alive, last_pix, request;

    always_comb begin
        state_d        = state_q;
        px_d           = px_q;
        py_d           = py_q;
        col_d          = col_q;
        row_d          = row_q;
        new_offset_d   = new_offset_q;
        drawn_offset_d = drawn_offset_q;
        has_drawn_d    = has_drawn_q;
        mask_d         = mask_q;
        x_d            = x_q;
        y_d            = y_q;
        colour_d       = colour_q;
        plot_d         = 1'b0;
        done_d         = 1'b0;

        request    = drawEn && !gameOver && (!has_drawn_q || rowOffset != drawn_offset_q);
        cur_offset = (state_q == S_ERASE) ? drawn_offset_q : new_offset_q;
        x_pix      = CW'(X_ORIGIN) + CW'(col_q) * CW'(X_SPACING) + CW'(px_q);
        y_pix      = CW'(Y_ORIGIN) + CW'(cur_offset) + CW'(row_q) * CW'(Y_SPACING) + CW'(py_q);
        on_screen  = (x_pix < CW'(SCR_W)) && (y_pix < CW'(SCR_H));
        mask_idx   = IDX_W'(row_q) * IDX_W'(ALIEN_COLS) + IDX_W'(col_q);
        alive      = |(mask_q & (MASK_W'(1) << mask_idx));
        last_pix   = (px_q == PX_W'(ALIEN_W - 1)) && (py_q == PY_W'(ALIEN_H - 1)) &&
                     (col_q == COL_W'(ALIEN_COLS - 1)) && (row_q == ROW_W'(ALIEN_ROWS - 1));

        // Pixel walk: px fastest, then py, col, row; wraps to zero after the last pixel.
        if (state_q == S_ERASE || state_q == S_DRAW) begin
            x_d = x_pix[7:0];
            y_d = y_pix[6:0];
            if (px_q == PX_W'(ALIEN_W - 1)) begin
                px_d = '0;
                if (py_q == PY_W'(ALIEN_H - 1)) begin
                    py_d = '0;
                    if (col_q == COL_W'(ALIEN_COLS - 1)) begin
                        col_d = '0;
                        row_d = (row_q == ROW_W'(ALIEN_ROWS - 1)) ? '0 : row_q + ROW_W'(1);
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end else begin
                    py_d = py_q + PY_W'(1);
                end
            end else begin
                px_d = px_q + PX_W'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (request) state_d = S_LATCH;
            end
            S_LATCH: begin
                new_offset_d = rowOffset;
                mask_d       = aliveMask;
                px_d         = '0;
                py_d         = '0;
                col_d        = '0;
                row_d        = '0;
                state_d      = has_drawn_q ? S_ERASE : S_DRAW;
            end
            S_ERASE: begin
                colour_d = BG_COLOUR;
                plot_d   = on_screen;
                if (last_pix) state_d = S_DRAW;
            end
            S_DRAW: begin
                colour_d = ALIEN_COLOUR;
                plot_d   = on_screen && alive;
                if (last_pix) state_d = S_DONE;
            end
            S_DONE: begin
                drawn_offset_d = new_offset_q;
                has_drawn_d    = 1'b1;
                done_d         = 1'b1;
                state_d        = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Game over abandons the pass without touching the record of what is on screen.
        if (gameOver && state_q != S_IDLE) begin
            state_d        = S_IDLE;
            plot_d         = 1'b0;
            done_d         = 1'b0;
            drawn_offset_d = drawn_offset_q;
            has_drawn_d    = has_drawn_q;
            px_d           = '0;
            py_d           = '0;
            col_d          = '0;
            row_d          = '0;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q        <= S_IDLE;
            px_q           <= '0;
            py_q           <= '0;
            col_q          <= '0;
            row_q          <= '0;
            new_offset_q   <= '0;
            drawn_offset_q <= '0;
            has_drawn_q    <= 1'b0;
            mask_q         <= '0;
            x_q            <= '0;
            y_q            <= '0;
            colour_q       <= '0;
            plot_q         <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            px_q           <= px_d;
            py_q           <= py_d;
            col_q          <= col_d;
            row_q          <= row_d;
            new_offset_q   <= new_offset_d;
            drawn_offset_q <= drawn_offset_d;
            has_drawn_q    <= has_drawn_d;
            mask_q         <= mask_d;
            x_q            <= x_d;
            y_q            <= y_d;
            colour_q       <= colour_d;
            plot_q         <= plot_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    assign x      = x_q;
    assign y      = y_q;
    assign colour = colour_q;
    assign plot   = plot_q;
    assign busy   = busy_q;
    assign done   = done_q;
endmodule

// File: tb/tb_alien_grid_renderer.sv
// Scoreboard bench for alien_grid_renderer: a reference pixel walk queues every expected
// plot and done event with its cycle; a negedge monitor pops and compares them.
module tb_alien_grid_renderer;
    localparam int unsigned N = 768;

    typedef struct packed {
        logic        is_done;
        logic [31:0] cyc;
        logic [7:0]  x;
        logic [6:0]  y;
        logic [2:0]  col;
    } evt_t;

    logic        clk, rst, draw_en, game_over;
    logic [5:0]  row_offset;
    logic [23:0] alive_mask;
    logic [7:0]  x0, x1;
    logic [6:0]  y0, y1;
    logic [2:0]  col0, col1;
    logic        plot0, plot1, busy0, busy1, done0, done1;

    int unsigned cyc = 0;
    int unsigned n_total = 0;
    int unsigned n_pass = 0;
    evt_t sb0[$];
    evt_t sb1[$];

    alien_grid_renderer dut0 (
        .Clock(clk), .Reset(rst), .drawEn(draw_en), .rowOffset(row_offset),
        .gameOver(game_over), .aliveMask(alive_mask),
        .x(x0), .y(y0), .colour(col0), .plot(plot0), .busy(busy0), .done(done0)
    );

    alien_grid_renderer #(.Y_ORIGIN(100)) dut1 (
        .Clock(clk), .Reset(rst), .drawEn(draw_en), .rowOffset(row_offset),
        .gameOver(game_over), .aliveMask(alive_mask),
        .x(x1), .y(y1), .colour(col1), .plot(plot1), .busy(busy1), .done(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h, required %0h (cyc %0d)", name, act, exp, cyc);
        else n_pass++;
    endtask

    task automatic push_evt(input int id, input evt_t e);
        if (id == 0) sb0.push_back(e);
        else sb1.push_back(e);
    endtask

    task automatic observe(input int id, input logic is_done, input logic [7:0] ax,
                           input logic [6:0] ay, input logic [2:0] ac);
        evt_t e;
        bit   empty;
        n_total++;
        empty = (id == 0) ? (sb0.size() == 0) : (sb1.size() == 0);
        if (empty) begin
            $display("FAIL unexpected_%s dut%0d: got x=%0d y=%0d colour=%0d at cyc %0d, required no activity",
                     is_done ? "done" : "plot", id, ax, ay, ac, cyc);
        end else begin
            e = (id == 0) ? sb0.pop_front() : sb1.pop_front();
            if (e.is_done !== is_done || e.cyc != cyc ||
                (!is_done && (e.x !== ax || e.y !== ay || e.col !== ac)))
                $display("FAIL event dut%0d: got done=%0b cyc=%0d x=%0d y=%0d colour=%0d, required done=%0b cyc=%0d x=%0d y=%0d colour=%0d",
                         id, is_done, cyc, ax, ay, ac, e.is_done, e.cyc, e.x, e.y, e.col);
            else n_pass++;
        end
    endtask

    always @(negedge clk) begin
        if (plot0) observe(0, 1'b0, x0, y0, col0);
        if (done0) observe(0, 1'b1, x0, y0, col0);
        if (plot1) observe(1, 1'b0, x1, y1, col1);
        if (done1) observe(1, 1'b1, x1, y1, col1);
    end

    // Reference walk: row, col, py, px; only on-screen (and, for draw, alive) pixels plot.
    task automatic push_phase(input int id, input bit erase, input logic [5:0] off,
                              input logic [23:0] mask, input int unsigned base,
                              input int unsigned limit);
        int unsigned k = 0;
        int          yo = (id == 0) ? 8 : 100;
        int          xx, yy;
        logic [23:0] m;
        evt_t        e;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 8; c++)
                for (int py = 0; py < 4; py++)
                    for (int px = 0; px < 8; px++) begin
                        xx = 16 + c * 12 + px;
                        yy = yo + int'(off) + r * 8 + py;
                        m  = mask >> (r * 8 + c);
                        if (k < limit && xx <= 159 && yy <= 119 && (erase || m[0])) begin
                            e.is_done = 1'b0;
                            e.cyc     = base + k;
                            e.x       = 8'(xx);
                            e.y       = 7'(yy);
                            e.col     = erase ? 3'b000 : 3'b010;
                            push_evt(id, e);
                        end
                        k++;
                    end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic run_pass(input logic [5:0] off, input logic [23:0] mask,
                            input bit erase, input logic [5:0] prev);
        int unsigned c0 = cyc + 1;
        int unsigned ph = erase ? 2 : 1;
        evt_t        e;
        for (int id = 0; id < 2; id++) begin
            if (erase) push_phase(id, 1'b1, prev, mask, c0 + 2, N);
            push_phase(id, 1'b0, off, mask, c0 + 2 + (ph - 1) * N, N);
            e = '0;
            e.is_done = 1'b1;
            e.cyc     = c0 + 2 + ph * N;
            push_evt(id, e);
        end
        row_offset = off;
        alive_mask = mask;
        draw_en    = 1'b1;
        tick();
        draw_en = 1'b0;
        chk("busy_at_latch", 32'(busy0), 32'd1);
        while (cyc < c0 + 3 + ph * N) tick();
        chk("busy_after_pass", 32'(busy0), 32'd0);
        chk("done_single_cycle", 32'(done0), 32'd0);
    endtask

    initial begin
        int unsigned c0;
        rst = 1'b1; draw_en = 1'b0; game_over = 1'b0; row_offset = '0; alive_mask = '1;
        repeat (3) tick();
        chk("rst_x", 32'(x0), 32'd0);
        chk("rst_y", 32'(y0), 32'd0);
        chk("rst_colour", 32'(col0), 32'd0);
        chk("rst_plot", 32'(plot0), 32'd0);
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_done", 32'(done0), 32'd0);
        chk("rst_plot_dut1", 32'(plot1), 32'd0);
        rst = 1'b0;
        tick();

        // First pass at offset 0: draw only.
        run_pass(6'd0, 24'hFFFFFF, 1'b0, 6'd0);

        // Level drawEn with unchanged offset must not retrigger.
        row_offset = 6'd0;
        draw_en    = 1'b1;
        repeat (20) tick();
        draw_en = 1'b0;
        chk("no_retrigger_busy", 32'(busy0), 32'd0);

        // Offset change: erase at 0, draw at 1.
        run_pass(6'd1, 24'hFFFFFF, 1'b1, 6'd0);

        do_reset();
        run_pass(6'd0, 24'h000001, 1'b0, 6'd0);
        do_reset();
        run_pass(6'd40, 24'hFFFFFF, 1'b0, 6'd0);
        do_reset();
        run_pass(6'd63, 24'hFFFFFF, 1'b0, 6'd0);

        // Abort at draw pixel 100 of a first pass.
        do_reset();
        c0 = cyc + 1;
        push_phase(0, 1'b0, 6'd5, 24'hFFFFFF, c0 + 2, 100);
        push_phase(1, 1'b0, 6'd5, 24'hFFFFFF, c0 + 2, 100);
        row_offset = 6'd5;
        alive_mask = 24'hFFFFFF;
        draw_en    = 1'b1;
        tick();
        draw_en = 1'b0;
        repeat (101) tick();
        game_over = 1'b1;
        tick();
        chk("abort_plot", 32'(plot0), 32'd0);
        chk("abort_busy", 32'(busy0), 32'd0);
        chk("abort_plot_dut1", 32'(plot1), 32'd0);
        draw_en = 1'b1;
        repeat (10) tick();
        chk("gameover_blocks_busy", 32'(busy0), 32'd0);
        game_over = 1'b0;
        draw_en   = 1'b0;
        tick();
        run_pass(6'd5, 24'hFFFFFF, 1'b0, 6'd0);

        // Reset at erase pixel 50; next pass must be draw only.
        c0 = cyc + 1;
        push_phase(0, 1'b1, 6'd5, 24'hFFFFFF, c0 + 2, 50);
        push_phase(1, 1'b1, 6'd5, 24'hFFFFFF, c0 + 2, 50);
        row_offset = 6'd7;
        draw_en    = 1'b1;
        tick();
        draw_en = 1'b0;
        repeat (51) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_x", 32'(x0), 32'd0);
        chk("midrst_y", 32'(y0), 32'd0);
        chk("midrst_colour", 32'(col0), 32'd0);
        chk("midrst_plot", 32'(plot0), 32'd0);
        chk("midrst_busy", 32'(busy0), 32'd0);
        chk("midrst_done", 32'(done0), 32'd0);
        run_pass(6'd7, 24'hFFFFFF, 1'b0, 6'd0);

        repeat (5) tick();
        chk("sb0_drained", 32'(sb0.size()), 32'd0);
        chk("sb1_drained", 32'(sb1.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule
